instruction_fetch: RTL and testbench

//  Fetch stage between program_counter and decode. Reads the current pc, issues a

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch stage between program_counter and decode.
// Ports: clk, reset (async, active-high); pc in / pc_count out to program_counter;
//   flush in (redirect, also program_counter.load); mem_req/mem_addr/mem_gnt/
//   mem_rvalid/mem_rdata instruction bus; instr_valid/instr_ready/instr/instr_pc to decode.
module instruction_fetch #(
   parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_count,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_DISC = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;

   logic [2:0]  w_state_nxt;
   logic        w_req;
   logic        w_grant;
   logic        w_load;
   logic        w_clear;

   // A flush suppresses the request so the reloaded pc is fetched next cycle.
   assign w_req       = (r_state == S_REQ) & ~flush;
   assign w_grant     = w_req & mem_gnt;
   assign mem_req     = w_req;
   assign mem_addr    = pc;
   assign pc_count    = w_grant;
   assign instr_valid = (r_state == S_HOLD);
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = S_REQ;
         S_REQ: begin
            if (w_grant) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A flush with data in hand drops it and refetches at once;
            // otherwise the stale response still has to be absorbed.
            if (flush) begin
               w_state_nxt = mem_rvalid ? S_REQ : S_DISC;
            end else if (mem_rvalid) begin
               w_state_nxt = S_HOLD;
               w_load      = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush || instr_ready) begin
               w_state_nxt = S_REQ;
               w_clear     = 1'b1;
            end
         end
         S_DISC: begin
            if (mem_rvalid) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= 32'd0;
         r_instr    <= RESET_INSTR;
         r_instr_pc <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) r_fetch_pc <= pc;
         if (w_load) begin
            r_instr    <= mem_rdata;
            r_instr_pc <= r_fetch_pc;
         end else if (w_clear) begin
            r_instr <= RESET_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized scoreboard bench for instruction_fetch with
// a program_counter model, a latency-randomized bus model and a decode model.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        pc_count;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;

   int k_gnt, k_lat_min, k_lat_max, k_ready, k_flush, k_flush_rv;

   logic [31:0] redir;
   logic [31:0] exp_next;
   exp_t        sb[$];

   instruction_fetch #(.RESET_INSTR(RESET_INSTR)) dut (
      .clk(clk), .reset(reset), .pc(pc), .pc_count(pc_count),
      .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'd0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic bit pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 3))
         0:       return 32'h0000_0100;
         1:       return $urandom & ~32'h3;
         2:       return 32'hFFFF_FFF8;
         default: return $urandom;
      endcase
   endfunction

   // Environment: program_counter, bus and decode models plus scoreboard push.
   initial begin : env
      logic [31:0] pc_n;
      logic [31:0] baddr;
      bit          pend;
      int          cnt;
      pc_n = 0; baddr = 0; pend = 0; cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb.delete();
            exp_next = 32'd0;
            pend     = 0;
            pc_n     = 32'd0;
         end else begin
            if (mem_req && mem_gnt) begin
               chk("grant_addr", mem_addr, exp_next);
               sb.push_back('{exp_next, memf(exp_next)});
               exp_next = exp_next + 32'd4;
               pend  = 1;
               cnt   = $urandom_range(k_lat_min, k_lat_max);
               baddr = mem_addr;
            end
            if (flush) begin
               sb.delete();
               exp_next = redir;
            end
            pc_n = flush ? redir : (pc_count ? pc + 32'd4 : pc);
         end
         @(posedge clk);
         #1;
         pc         = pc_n;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = memf(baddr);
               pend       = 0;
            end
         end
         mem_gnt     = pct(k_gnt);
         instr_ready = pct(k_ready);
         flush       = 1'b0;
         if (!reset) flush = pct(k_flush) || (mem_rvalid && pct(k_flush_rv));
         if (flush) redir = pick_target();
      end
   end

   // Monitor: pops the scoreboard on every accepted word, checks hold/flush rules.
   initial begin : mon
      logic        p_hold, p_fl_rv, p_fl_v;
      logic [31:0] p_i, p_pc;
      exp_t        e;
      p_hold = 0; p_fl_rv = 0; p_fl_v = 0; p_i = 0; p_pc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            p_hold = 0; p_fl_rv = 0; p_fl_v = 0;
         end else begin
            if (p_hold) begin
               chk("hold_valid", 32'(instr_valid), 32'd1);
               chk("hold_instr", instr, p_i);
               chk("hold_pc", instr_pc, p_pc);
               chk("hold_noreq", 32'(mem_req), 32'd0);
            end
            if (p_fl_rv && !flush) chk("req_after_flush_rv", 32'(mem_req), 32'd1);
            if (p_fl_v) chk("drop_on_flush", 32'(instr_valid), 32'd0);
            if (flush) chk("no_req_in_flush", 32'(mem_req), 32'd0);
            if (!instr_valid) chk("idle_instr", instr, RESET_INSTR);
            if (instr_valid && instr_ready && !flush) begin
               chk("sb_size", 32'(sb.size()), 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("word_pc", instr_pc, e.a);
                  chk("word_instr", instr, e.d);
               end
               n_acc++;
            end
            p_hold  = instr_valid && !instr_ready && !flush;
            p_i     = instr;
            p_pc    = instr_pc;
            p_fl_rv = flush && mem_rvalid;
            p_fl_v  = flush && instr_valid;
         end
      end
   end

   initial begin : main
      reset = 1'b1; flush = 1'b0; pc = 32'd0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'd0; instr_ready = 1'b0;
      redir = 32'd0; exp_next = 32'd0;
      k_gnt = 100; k_lat_min = 1; k_lat_max = 1; k_ready = 0;
      k_flush = 0; k_flush_rv = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, RESET_INSTR);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_count", 32'(pc_count), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;

      // first fetch: idle gap, grant at cycle 2, word valid at cycle 4
      @(negedge clk);
      chk("c1_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      chk("c2_req", 32'(mem_req), 32'd1);
      chk("c2_addr", mem_addr, 32'd0);
      chk("c2_count", 32'(pc_count), 32'd1);
      @(negedge clk);
      chk("c3_count", 32'(pc_count), 32'd0);
      chk("c3_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("c4_valid", 32'(instr_valid), 32'd1);
      chk("c4_instr", instr, 32'h0050_0093);
      chk("c4_pc", instr_pc, 32'd0);

      // decode stalls five cycles
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_req", 32'(mem_req), 32'd0);
         chk("stall_count", 32'(pc_count), 32'd0);
      end
      k_ready = 100;
      k_gnt   = 0;
      @(negedge clk);
      chk("acc_valid", 32'(instr_valid), 32'd1);
      @(negedge clk);
      chk("post_acc_valid", 32'(instr_valid), 32'd0);
      chk("post_acc_req", 32'(mem_req), 32'd1);

      // grant withheld for three cycles
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         chk("wait_gnt_req", 32'(mem_req), 32'd1);
         chk("wait_gnt_addr", mem_addr, 32'd4);
         chk("wait_gnt_count", 32'(pc_count), 32'd0);
      end
      k_gnt = 100;
      @(negedge clk);
      chk("late_gnt_count", 32'(pc_count), 32'd1);
      chk("late_gnt_addr", mem_addr, 32'd4);
      @(negedge clk);
      chk("late_gnt_after", 32'(pc_count), 32'd0);

      // randomized segments with flushes and one mid-run reset
      for (int seg = 0; seg < 6; seg++) begin
         k_gnt      = $urandom_range(30, 100);
         k_lat_min  = 1;
         k_lat_max  = $urandom_range(1, 4);
         k_ready    = $urandom_range(20, 100);
         k_flush    = $urandom_range(2, 15);
         k_flush_rv = $urandom_range(10, 60);
         if (seg == 3) begin
            @(posedge clk);
            #3 reset = 1'b1;
            #1;
            chk("midrst_valid", 32'(instr_valid), 32'd0);
            chk("midrst_req", 32'(mem_req), 32'd0);
            chk("midrst_instr", instr, RESET_INSTR);
            @(posedge clk);
            @(posedge clk);
            #2 reset = 1'b0;
         end
         repeat (400) @(negedge clk);
      end
      k_flush = 0;
      k_flush_rv = 0;
      k_ready = 100;
      k_gnt = 100;
      repeat (20) @(negedge clk);
      chk("progress", 32'(n_acc >= 30), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
